// File: rtl/demux_pkg.sv
// Shared lane count, lane-select type and pointer helper for the buffered 1:4 demux.
package demux_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_sel_t;

    // Round-robin successor; two bits wrap 3 -> 0 naturally.
    function automatic lane_sel_t lane_next(input lane_sel_t cur);
        return cur + lane_sel_t'(1);
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry holding register for a single output lane: loads on accept, clears valid on drain.
module demux_lane_reg #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] data_o,
    output logic         valid_o
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    // A load in the same cycle as a drain wins, so the lane keeps full throughput.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (valid_q && drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_nto4n_buf.sv
// Buffered 1:4 distributor: routes one N-bit word per handshake into one of four
// independently drained lane registers, selected by S or a round-robin pointer.
module demux_nto4n_buf
    import demux_pkg::*;
#(
    parameter int N = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          auto_sel,
    input  logic [1:0]                    S,
    input  logic [N-1:0]                  I,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_LANES-1:0][N-1:0]   O,
    output logic [NUM_LANES-1:0]          o_valid,
    input  logic [NUM_LANES-1:0]          o_ready,
    output logic [1:0]                    ptr,
    output logic                          busy
);

    lane_sel_t              sel;
    lane_sel_t              ptr_q, ptr_d;
    logic                   accept;
    logic [NUM_LANES-1:0]   load;

    assign sel = auto_sel ? ptr_q : S;

    // Ready depends only on the selected lane's state, never on in_valid.
    assign in_ready = ~rst & enable & (~o_valid[sel] | o_ready[sel]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        ptr_d = ptr_q;
        if (accept && auto_sel) begin
            ptr_d = lane_next(ptr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign load[gi] = accept && (sel == lane_sel_t'(gi));

            demux_lane_reg #(
                .N (N)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .load_i  (load[gi]),
                .drain_i (o_ready[gi]),
                .data_i  (I),
                .data_o  (O[gi]),
                .valid_o (o_valid[gi])
            );
        end
    endgenerate

    assign ptr  = ptr_q;
    assign busy = |o_valid;

endmodule

// File: tb/tb_demux_nto4n_buf.sv
// Scoreboard bench for demux_nto4n_buf: accepted words are queued per expected lane,
// a monitor pops and compares each lane word when it is handed to its consumer.
module tb_demux_nto4n_buf;

    localparam int N = 24;

    logic                clk;
    logic                rst;
    logic                enable;
    logic                auto_sel;
    logic [1:0]          S;
    logic [N-1:0]        I;
    logic                in_valid;
    logic                in_ready;
    logic [3:0][N-1:0]   O;
    logic [3:0]          o_valid;
    logic [3:0]          o_ready;
    logic [1:0]          ptr;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int exp_lane = 0;
    logic [N-1:0] exp_q [4][$];

    demux_nto4n_buf #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .auto_sel (auto_sel),
        .S        (S),
        .I        (I),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .O        (O),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .ptr      (ptr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: the stimulus decides the lane, the handshake decides the moment.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q[exp_lane].push_back(I);
        end
    end

    // Monitor: every word handed to a consumer must match the oldest expected word of its lane.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (o_valid[k] && o_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lane%0d_unexpected: got %0h expected none", k, O[k]);
                end else begin
                    check($sformatf("lane%0d_data", k), 96'(O[k]), 96'(exp_q[k].pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; auto_sel = 1'b0; S = 2'd0;
        I = '0; in_valid = 1'b0; o_ready = 4'b0000;
        repeat (2) tick();
        @(negedge clk);
        check("rst_o_valid", 96'(o_valid), 96'h0);
        check("rst_O", 96'(O), 96'h0);
        check("rst_ptr", 96'(ptr), 96'h0);
        check("rst_busy", 96'(busy), 96'h0);
        check("rst_in_ready", 96'(in_ready), 96'h0);
        tick(); rst = 1'b0;

        // Explicit select, then back-pressure on the same lane
        exp_lane = 2; S = 2'd2; I = 24'hABCDEF; in_valid = 1'b1;
        @(negedge clk); check("exp_in_ready", 96'(in_ready), 96'h1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("exp_o_valid", 96'(o_valid), 96'h4);
        check("exp_O2", 96'(O[2]), 96'hABCDEF);
        check("exp_busy", 96'(busy), 96'h1);
        tick(); I = 24'h123456; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("blk_in_ready", 96'(in_ready), 96'h0);
            check("blk_O2_stable", 96'(O[2]), 96'hABCDEF);
            tick();
        end
        o_ready = 4'b0100;
        @(negedge clk); check("unblk_in_ready", 96'(in_ready), 96'h1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("unblk_o_valid2", 96'(o_valid[2]), 96'h1);
        check("unblk_O2", 96'(O[2]), 96'h123456);
        tick(); o_ready = 4'b0000;
        @(negedge clk); check("exp_drained", 96'(o_valid), 96'h0);

        // Round-robin over all lanes with wrap
        tick(); auto_sel = 1'b1; o_ready = 4'hF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_lane = i % 4; I = N'(i + 1);
            @(negedge clk);
            check("rr_ptr", 96'(ptr), 96'(i % 4));
            check("rr_in_ready", 96'(in_ready), 96'h1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk); check("rr_ptr_final", 96'(ptr), 96'h1);

        // Stall isolation: lane 1 blocked, lane 3 flows
        tick(); auto_sel = 1'b0; o_ready = 4'b1101;
        S = 2'd1; exp_lane = 1; I = 24'h111111; in_valid = 1'b1;
        @(negedge clk); check("st_in_ready1", 96'(in_ready), 96'h1);
        tick(); S = 2'd3; exp_lane = 3; I = 24'h333333;
        @(negedge clk);
        check("st_in_ready3", 96'(in_ready), 96'h1);
        check("st_O1", 96'(O[1]), 96'h111111);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("st_o_valid", 96'(o_valid), 96'hA);
        check("st_O1_stable", 96'(O[1]), 96'h111111);
        tick();
        @(negedge clk); check("st_lane3_gone", 96'(o_valid), 96'h2);
        tick(); o_ready = 4'b0010;
        @(negedge clk);
        tick(); o_ready = 4'b0000;
        @(negedge clk); check("st_drained", 96'(o_valid), 96'h0);

        // Drain and fill lane 0 in the same cycle
        tick(); S = 2'd0; exp_lane = 0; I = 24'hAAAAAA; in_valid = 1'b1;
        @(negedge clk); check("df_first", 96'(in_ready), 96'h1);
        tick(); I = 24'hBBBBBB; o_ready = 4'b0001;
        @(negedge clk);
        check("df_in_ready", 96'(in_ready), 96'h1);
        check("df_valid_before", 96'(o_valid[0]), 96'h1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("df_no_bubble", 96'(o_valid[0]), 96'h1);
        check("df_O0", 96'(O[0]), 96'hBBBBBB);
        tick(); o_ready = 4'b0000;
        @(negedge clk); check("df_drained", 96'(o_valid), 96'h0);

        // enable=0: intake blocked, pointer frozen, lane still drains
        tick(); auto_sel = 1'b1; exp_lane = 1; I = 24'h666666; in_valid = 1'b1;
        @(negedge clk);
        check("en_ptr_before", 96'(ptr), 96'h1);
        check("en_in_ready_on", 96'(in_ready), 96'h1);
        tick(); enable = 1'b0; exp_lane = 2; I = 24'h777777; o_ready = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("en_in_ready_off", 96'(in_ready), 96'h0);
            check("en_ptr_frozen", 96'(ptr), 96'h2);
            tick();
        end
        @(negedge clk); check("en_drained", 96'(o_valid), 96'h0);
        tick(); in_valid = 1'b0; enable = 1'b1; o_ready = 4'b0000;

        // Reset mid-stream with lanes 0 and 2 full
        auto_sel = 1'b0; S = 2'd0; exp_lane = 0; I = 24'h0A0A0A; in_valid = 1'b1;
        @(negedge clk);
        tick(); S = 2'd2; exp_lane = 2; I = 24'h0C0C0C;
        @(negedge clk);
        tick(); S = 2'd1; exp_lane = 1; I = 24'hDDDDDD;
        check("mid_o_valid", 96'(o_valid), 96'h5);
        rst = 1'b1;
        #1;
        check("mid_rst_o_valid", 96'(o_valid), 96'h0);
        check("mid_rst_O", 96'(O), 96'h0);
        check("mid_rst_ptr", 96'(ptr), 96'h0);
        check("mid_rst_in_ready", 96'(in_ready), 96'h0);
        check("mid_rst_busy", 96'(busy), 96'h0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk); check("mid_rst_hold", 96'(o_valid), 96'h0);
        tick(); rst = 1'b0; in_valid = 1'b0;

        // Traffic resumes after reset
        S = 2'd3; exp_lane = 3; I = 24'hFEDCBA; in_valid = 1'b1; o_ready = 4'b1000;
        @(negedge clk); check("post_in_ready", 96'(in_ready), 96'h1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        tick(); o_ready = 4'b0000;
        @(negedge clk);
        check("post_o_valid", 96'(o_valid), 96'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lane%0d_leftover", k), 96'(exp_q[k].size()), 96'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
